// File: rtl/ex_mc_ctrl.sv
// EX-stage stall combiner and multi-cycle sequencer (MADD/MSUB state, iterative divider handshake).
// Optional: define DIV_ZERO_BYPASS_EN to complete a divide by zero without starting the divider.
module ex_mc_ctrl #(
    parameter int WIDTH   = 32,
    parameter int STALL_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 stallreq_id,
    input  logic                 stallreq_ex,
    input  logic [1:0]           ex_cnt_i,
    input  logic [2*WIDTH-1:0]   ex_hilo_temp_i,
    output logic [1:0]           cnt_o,
    output logic [2*WIDTH-1:0]   hilo_temp_o,
    input  logic                 div_req_i,
    input  logic                 div_signed_i,
    input  logic [WIDTH-1:0]     div_op1_i,
    input  logic [WIDTH-1:0]     div_op2_i,
    output logic                 div_start_o,
    output logic                 div_annul_o,
    output logic                 div_signed_o,
    output logic [WIDTH-1:0]     div_op1_o,
    output logic [WIDTH-1:0]     div_op2_o,
    input  logic                 div_ready_i,
    input  logic [2*WIDTH-1:0]   div_result_i,
    output logic                 div_ready_o,
    output logic [2*WIDTH-1:0]   div_result_o,
    output logic [STALL_W-1:0]   stall,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    logic [1:0] state;
    logic       div_ready_q;
    logic       stallreq_div;
    logic       div_enter;
    logic       div_zero;

    assign state_dbg    = state;
    assign div_enter    = (state == IDLE) && div_req_i && !flush;
    assign div_zero     = ZERO_BYPASS && (div_op2_i == '0);
    assign stallreq_div = div_enter || (state == DIV_RUN);

    // The result cycle must not leak to EX if an exception flushes it.
    assign div_ready_o = div_ready_q && !flush;

    always_comb begin
        stall = '0;
        if (rst) begin
            stall = '0;
        end else if (stallreq_ex || stallreq_div) begin
            stall[3:0] = 4'b1111;
        end else if (stallreq_id) begin
            stall[2:0] = 3'b111;
        end
    end

    // Divider handshake: div_start_o is a level held with stable operands until
    // the divider pulses div_ready_i for one cycle; div_annul_o aborts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            div_ready_q  <= 1'b0;
            div_result_o <= '0;
        end else begin
            div_annul_o <= 1'b0;
            div_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_enter) begin
                        div_signed_o <= div_signed_i;
                        div_op1_o    <= div_op1_i;
                        div_op2_o    <= div_op2_i;
                        if (div_zero) begin
                            state        <= DIV_DONE;
                            div_ready_q  <= 1'b1;
                            div_result_o <= '0;
                        end else begin
                            state       <= DIV_RUN;
                            div_start_o <= 1'b1;
                        end
                    end
                end
                DIV_RUN: begin
                    if (flush) begin
                        state       <= IDLE;
                        div_start_o <= 1'b0;
                        div_annul_o <= 1'b1;
                    end else if (div_ready_i) begin
                        state        <= DIV_DONE;
                        div_start_o  <= 1'b0;
                        div_ready_q  <= 1'b1;
                        div_result_o <= div_result_i;
                    end
                end
                default: begin
                    state       <= IDLE;
                    div_start_o <= 1'b0;
                end
            endcase
        end
    end

    // MADD/MSUB carry state survives only across the stalled EX cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt_o       <= '0;
            hilo_temp_o <= '0;
        end else if (stall[3] && !stall[4]) begin
            cnt_o       <= ex_cnt_i;
            hilo_temp_o <= ex_hilo_temp_i;
        end else if (!stall[3]) begin
            cnt_o       <= '0;
            hilo_temp_o <= '0;
        end
    end

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Directed self-checking bench for ex_mc_ctrl; results of divides are queued in exp_q.
module tb_ex_mc_ctrl;

    localparam int WIDTH   = 32;
    localparam int STALL_W = 6;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               stallreq_id;
    logic               stallreq_ex;
    logic [1:0]         ex_cnt_i;
    logic [2*WIDTH-1:0] ex_hilo_temp_i;
    logic [1:0]         cnt_o;
    logic [2*WIDTH-1:0] hilo_temp_o;
    logic               div_req_i;
    logic               div_signed_i;
    logic [WIDTH-1:0]   div_op1_i;
    logic [WIDTH-1:0]   div_op2_i;
    logic               div_start_o;
    logic               div_annul_o;
    logic               div_signed_o;
    logic [WIDTH-1:0]   div_op1_o;
    logic [WIDTH-1:0]   div_op2_o;
    logic               div_ready_i;
    logic [2*WIDTH-1:0] div_result_i;
    logic               div_ready_o;
    logic [2*WIDTH-1:0] div_result_o;
    logic [STALL_W-1:0] stall;
    logic [1:0]         state_dbg;

    logic [2*WIDTH-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    ex_mc_ctrl #(.WIDTH(WIDTH), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .ex_cnt_i(ex_cnt_i), .ex_hilo_temp_i(ex_hilo_temp_i),
        .cnt_o(cnt_o), .hilo_temp_o(hilo_temp_o),
        .div_req_i(div_req_i), .div_signed_i(div_signed_i),
        .div_op1_i(div_op1_i), .div_op2_i(div_op2_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .div_ready_o(div_ready_o), .div_result_o(div_result_o),
        .stall(stall), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        flush = 0; stallreq_id = 0; stallreq_ex = 0;
        ex_cnt_i = 0; ex_hilo_temp_i = 0;
        div_req_i = 0; div_signed_i = 0; div_op1_i = 0; div_op2_i = 0;
        div_ready_i = 0; div_result_i = 0;
    endtask

    task automatic start_div(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        div_req_i = 1; div_signed_i = sgn; div_op1_i = a; div_op2_i = b;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        idle_inputs();
        rst = 1;
        tick();
        settle();
        check("stall_in_rst", 64'(stall), 64'h0);
        tick();
        rst = 0;
        settle();
        check("rst_state", 64'(state_dbg), 64'h0);
        check("rst_start", 64'(div_start_o), 64'h0);
        check("rst_ready", 64'(div_ready_o), 64'h0);
        check("rst_cnt", 64'(cnt_o), 64'h0);
        check("rst_hilo", hilo_temp_o, 64'h0);
        check("rst_result", div_result_o, 64'h0);

        // stall priority
        stallreq_id = 1; settle();
        check("stall_id", 64'(stall), 64'h07);
        stallreq_ex = 1; settle();
        check("stall_id_ex", 64'(stall), 64'h0f);
        stallreq_id = 0; stallreq_ex = 0; settle();
        check("stall_none", 64'(stall), 64'h00);

        // MADD two-cycle sequence
        stallreq_ex = 1; ex_cnt_i = 2'b01; ex_hilo_temp_i = 64'h0000_0001_0000_0002;
        tick();
        stallreq_ex = 0; ex_cnt_i = 2'b10; ex_hilo_temp_i = 64'h0;
        settle();
        check("madd_cnt", 64'(cnt_o), 64'h1);
        check("madd_hilo", hilo_temp_o, 64'h0000_0001_0000_0002);
        check("madd_stall2", 64'(stall), 64'h0);
        tick();
        ex_cnt_i = 0;
        check("madd_cnt_clr", 64'(cnt_o), 64'h0);
        check("madd_hilo_clr", hilo_temp_o, 64'h0);

        // flush overrides capture of MADD state
        stallreq_ex = 1; ex_cnt_i = 2'b01; ex_hilo_temp_i = 64'hdead_beef_0000_0001; flush = 1;
        tick();
        idle_inputs();
        settle();
        check("flush_cnt", 64'(cnt_o), 64'h0);
        check("flush_hilo", hilo_temp_o, 64'h0);

        // request under flush does not enter the divider
        start_div(1, 32'd5, 32'd2); flush = 1; settle();
        check("req_flush_stall", 64'(stall), 64'h0);
        tick();
        idle_inputs(); settle();
        check("req_flush_state", 64'(state_dbg), 64'h0);
        check("req_flush_start", 64'(div_start_o), 64'h0);

        // DIV 100/7 signed, divider answers on the 33rd running cycle
        start_div(1, 32'd100, 32'd7); settle();
        check("div_req_stall", 64'(stall), 64'h0f);
        exp_q.push_back({32'd2, 32'd14});
        tick();
        check("div_run_state", 64'(state_dbg), 64'h1);
        check("div_start", 64'(div_start_o), 64'h1);
        check("div_op1", 64'(div_op1_o), 64'd100);
        check("div_op2", 64'(div_op2_o), 64'd7);
        check("div_signed", 64'(div_signed_o), 64'h1);
        for (int k = 1; k <= 33; k++) begin
            if (k == 33) begin
                div_ready_i = 1; div_result_i = {32'd2, 32'd14};
            end
            settle();
            check("div_run_stall", 64'(stall), 64'h0f);
            check("div_run_ready", 64'(div_ready_o), 64'h0);
            tick();
        end
        div_ready_i = 0; div_result_i = 0;
        settle();
        check("div_done_ready", 64'(div_ready_o), 64'h1);
        check("div_done_result", div_result_o, exp_q.pop_front());
        check("div_done_stall", 64'(stall), 64'h0);
        check("div_done_start", 64'(div_start_o), 64'h0);
        tick();
        div_req_i = 0; settle();
        check("div_back_idle", 64'(state_dbg), 64'h0);
        check("div_ready_once", 64'(div_ready_o), 64'h0);
        tick();
        check("div_no_restart", 64'(div_start_o), 64'h0);

        // flush on the 10th running cycle, with a coincident ready that must be dropped
        start_div(0, 32'd50, 32'd3);
        tick();
        for (int k = 1; k < 10; k++) tick();
        flush = 1; div_ready_i = 1; div_result_i = 64'h1234;
        settle();
        check("flush_run_stall", 64'(stall), 64'h0f);
        tick();
        idle_inputs(); settle();
        check("annul_pulse", 64'(div_annul_o), 64'h1);
        check("annul_start", 64'(div_start_o), 64'h0);
        check("annul_state", 64'(state_dbg), 64'h0);
        check("annul_ready", 64'(div_ready_o), 64'h0);
        tick();
        check("annul_one_cycle", 64'(div_annul_o), 64'h0);
        div_ready_i = 1; div_result_i = 64'h55;
        tick();
        div_ready_i = 0; div_result_i = 0; settle();
        check("late_ready_ignored", 64'(div_ready_o), 64'h0);
        check("late_state", 64'(state_dbg), 64'h0);

        // flush in the result cycle suppresses div_ready_o
        start_div(1, 32'd9, 32'd4);
        tick();
        div_ready_i = 1; div_result_i = {32'd1, 32'd2};
        tick();
        div_ready_i = 0; div_req_i = 0; flush = 1; settle();
        check("flush_done_ready", 64'(div_ready_o), 64'h0);
        tick();
        flush = 0; settle();
        check("flush_done_state", 64'(state_dbg), 64'h0);

        // synchronous reset in the middle of a divide
        start_div(1, 32'd77, 32'd5);
        tick(); tick(); tick();
        stallreq_ex = 1; ex_cnt_i = 2'b01;
        tick();
        rst = 1; settle();
        check("rst_mid_stall_comb", 64'(stall), 64'h0);
        tick();
        rst = 0; idle_inputs(); settle();
        check("rst_mid_stall", 64'(stall), 64'h0);
        check("rst_mid_start", 64'(div_start_o), 64'h0);
        check("rst_mid_ready", 64'(div_ready_o), 64'h0);
        check("rst_mid_cnt", 64'(cnt_o), 64'h0);
        check("rst_mid_state", 64'(state_dbg), 64'h0);

        // divisor zero
        start_div(1, 32'd123, 32'd0); settle();
        check("zero_req_stall", 64'(stall), 64'h0f);
        tick();
`ifdef DIV_ZERO_BYPASS_EN
        exp_q.push_back(64'h0);
        settle();
        check("zero_start", 64'(div_start_o), 64'h0);
        check("zero_ready", 64'(div_ready_o), 64'h1);
        check("zero_result", div_result_o, exp_q.pop_front());
        check("zero_stall_once", 64'(stall), 64'h0);
        tick();
        div_req_i = 0; settle();
        check("zero_idle", 64'(state_dbg), 64'h0);
        check("zero_start_after", 64'(div_start_o), 64'h0);
`else
        settle();
        check("zero_start", 64'(div_start_o), 64'h1);
        check("zero_op2", 64'(div_op2_o), 64'h0);
        check("zero_stall", 64'(stall), 64'h0f);
        flush = 1;
        tick();
        idle_inputs(); settle();
        check("zero_annul", 64'(div_annul_o), 64'h1);
        check("zero_idle", 64'(state_dbg), 64'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
